// File: rtl/zero_count_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | zero_count_unit: chunked leading/trailing zero/one counter with early exit
// | Revision: 1.0
// +----------------------------------------------------------------------------
module zero_count_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [1:0]               in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(WIDTH):0]   out_count,
  output logic                     out_all,
  output logic                     busy
);

  localparam int CNT_W  = $clog2(WIDTH) + 1;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  word_q, word_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              all_q, all_d;

  logic [WIDTH-1:0]  inv_data;
  logic [WIDTH-1:0]  norm_data;
  logic [CHUNK-1:0]  chunk;
  logic [CNT_W-1:0]  chunk_lz;

  // Every mode is folded into a leading-zero count on the normalised word.
  always_comb begin
    inv_data = in_mode[1] ? ~in_data : in_data;
    for (int i = 0; i < WIDTH; i++) begin
      norm_data[i] = in_mode[0] ? inv_data[WIDTH-1-i] : inv_data[i];
    end
  end

  // The word is shifted left each SCAN cycle, so the current chunk is always on top.
  assign chunk = word_q[WIDTH-1 -: CHUNK];

  always_comb begin
    chunk_lz = '0;
    for (int j = 0; j < CHUNK; j++) begin
      if (chunk[j]) chunk_lz = CNT_W'(CHUNK - 1 - j);
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    count_d = count_q;
    all_d   = all_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          word_d  = norm_data;
          idx_d   = '0;
          count_d = '0;
          all_d   = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        word_d = word_q << CHUNK;
        if (chunk == '0) begin
          if (idx_q == LAST_IDX) begin
            count_d = CNT_W'(WIDTH);
            all_d   = 1'b1;
            state_d = DONE;
          end else begin
            count_d = count_q + CNT_W'(CHUNK);
            idx_d   = idx_q + IDX_W'(1);
          end
        end else begin
          count_d = count_q + chunk_lz;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      count_q <= '0;
      all_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      all_q   <= all_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_count = count_q;
  assign out_all   = all_q;

endmodule
`default_nettype wire

// File: tb/tb_zero_count_unit.sv
`default_nettype none
// Testbench for zero_count_unit (WIDTH=32, CHUNK=8): table vectors, random
// vectors against a bit-serial model, back-pressure and mid-scan reset.
module tb_zero_count_unit;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_count;
  logic        out_all;
  logic        busy;

  zero_count_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
    .out_all(out_all), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  mode;
    int          count;
    logic        all;
    int          lat;
    int          hold;
  } vec_t;

  typedef struct {
    int   count;
    logic all;
    int   lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Bit-serial reference: walk from the relevant end counting the target bit value.
  function automatic int ref_count(input logic [31:0] d, input logic [1:0] m);
    int  c;
    bit  stop;
    int  pos;
    c = 0;
    stop = 0;
    for (int k = 0; k < 32; k++) begin
      pos = m[0] ? k : 31 - k;
      if (!stop && d[pos] == m[1]) c++;
      else stop = 1;
    end
    return c;
  endfunction

  function automatic int ref_lat(input int c);
    return (c == WIDTH) ? WIDTH / CHUNK : c / CHUNK + 1;
  endfunction

  task automatic do_op(input logic [31:0] d, input logic [1:0] m, input int hold);
    int   lat;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    check("in_ready_idle", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_mode  = 2'($urandom);
    lat = 0;
    while (!out_valid && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat < 12) begin
        in_data = $urandom;
        in_mode = 2'($urandom);
      end
    end
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      return;
    end
    e = sb_q[0];
    if (!out_valid) begin
      check("out_valid_timeout", 0, 1);
      void'(sb_q.pop_front());
      return;
    end
    check("latency", lat, e.lat);
    for (int h = 0; h < hold; h++) begin
      check("hold_count", out_count, e.count);
      check("hold_all", out_all, e.all);
      check("hold_in_ready", in_ready, 0);
      check("hold_busy", busy, 1);
      @(posedge clk);
      #1;
      check("hold_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    e = sb_q.pop_front();
    check("out_count", out_count, e.count);
    check("out_all", out_all, e.all);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("post_in_ready", in_ready, 1);
    check("post_out_valid", out_valid, 0);
    check("post_busy", busy, 0);
  endtask

  task automatic push_exp(input int c, input logic a, input int l);
    exp_t e;
    e.count = c;
    e.all   = a;
    e.lat   = l;
    sb_q.push_back(e);
  endtask

  vec_t vecs[11];

  initial begin
    logic [31:0] rd;
    logic [1:0]  rm;
    int          rc;
    int          seen;

    vecs[0]  = '{32'h0000_0000, 2'b00, 32, 1'b1, 4, 0};
    vecs[1]  = '{32'h8000_0000, 2'b00,  0, 1'b0, 1, 0};
    vecs[2]  = '{32'h0000_0200, 2'b01,  9, 1'b0, 2, 0};
    vecs[3]  = '{32'h0000_0001, 2'b01,  0, 1'b0, 1, 0};
    vecs[4]  = '{32'hFFFF_0FFF, 2'b10, 16, 1'b0, 3, 3};
    vecs[5]  = '{32'hFFFF_FFFF, 2'b11, 32, 1'b1, 4, 0};
    vecs[6]  = '{32'h0000_0001, 2'b00, 31, 1'b0, 4, 0};
    vecs[7]  = '{32'h0000_FFFF, 2'b00, 16, 1'b0, 3, 0};
    vecs[8]  = '{32'h0000_0000, 2'b11,  0, 1'b0, 1, 0};
    vecs[9]  = '{32'h7FFF_FFFF, 2'b10,  0, 1'b0, 1, 2};
    vecs[10] = '{32'h8000_0000, 2'b01, 31, 1'b0, 4, 0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_count", out_count, 0);
    check("reset_out_all", out_all, 0);
    check("reset_busy", busy, 0);
    check("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;

    // Idle with in_valid low must not move.
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", busy, 0);
    check("idle_in_ready", in_ready, 1);

    for (int i = 0; i < 11; i++) begin
      push_exp(vecs[i].count, vecs[i].all, vecs[i].lat);
      do_op(vecs[i].data, vecs[i].mode, vecs[i].hold);
    end

    for (int i = 0; i < 24; i++) begin
      rd = $urandom;
      if (i % 3 == 1) rd = rd >> $urandom_range(31, 0);
      if (i % 3 == 2) rd = rd | (32'hFFFF_FFFF << $urandom_range(31, 0));
      rm = 2'($urandom);
      rc = ref_count(rd, rm);
      push_exp(rc, rc == WIDTH, ref_lat(rc));
      do_op(rd, rm, i % 4);
    end

    // Reset during SCAN of an all-zero word discards the operation.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h0000_0000;
    in_mode  = 2'b00;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("scan_busy", busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    check("rst_hold_busy", busy, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    check("rst_no_result", seen, 0);

    // Unit still works after the aborted operation.
    push_exp(32, 1'b1, 4);
    do_op(32'h0000_0000, 2'b00, 1);

    check("scoreboard_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
